// File: rtl/round_timer_ctrl_if.sv
// Counter-side bus between round_timer_ctrl (master) and a flex counter (slave).
// The controller owns clear, enable and terminal value; the counter returns strobe and count.
interface round_timer_ctrl_if #(
  parameter int unsigned COUNTWIDTH = 10
);

  logic                  ctr_rst;
  logic                  enableCounter;
  logic [COUNTWIDTH-1:0] maxCount;
  logic                  strobe;
  logic [COUNTWIDTH-1:0] count;

  modport master (
    output ctr_rst,
    output enableCounter,
    output maxCount,
    input  strobe,
    input  count
  );

  modport slave (
    input  ctr_rst,
    input  enableCounter,
    input  maxCount,
    output strobe,
    output count
  );

endinterface

// File: rtl/round_timer_ctrl.sv
// Round timer: drives a flex counter and turns its strobes into ticks, elapsed count and done.
// Optional pause/hold support is built only when ROUNDTIMER_PAUSE_EN is defined.
module round_timer_ctrl #(
  parameter int unsigned COUNTSIZE  = 1024,
  parameter int unsigned COUNTWIDTH = $clog2(COUNTSIZE),
  parameter int unsigned ROUNDWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic                  abort,
`ifdef ROUNDTIMER_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [COUNTWIDTH-1:0] period,
  input  logic [ROUNDWIDTH-1:0] rounds,
  output logic                  ctr_clk,
  round_timer_ctrl_if.master    ctr,
  output logic                  tick,
  output logic [ROUNDWIDTH-1:0] elapsed,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3
`ifdef ROUNDTIMER_PAUSE_EN
    ,
    S_PAUSE = 3'd4
`endif
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [ROUNDWIDTH-1:0] target_q;
  logic [COUNTWIDTH-1:0] max_q;
  logic [ROUNDWIDTH-1:0] elapsed_q;
  logic [ROUNDWIDTH-1:0] elapsed_inc;
  logic                  tick_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  en_q;
  logic                  ctr_rst_q;

  logic                  load;
  logic                  clr_elapsed;
  logic                  inc_elapsed;

  assign elapsed_inc = elapsed_q + ROUNDWIDTH'(1);

  // State register
  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath controls; strobe only counts in RUN, abort outranks it
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    clr_elapsed = 1'b0;
    inc_elapsed = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_elapsed = 1'b1;
          if (rounds != '0) begin
            load    = 1'b1;
            state_d = S_ARM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ARM: begin
        state_d = S_RUN;
      end
`ifdef ROUNDTIMER_PAUSE_EN
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ctr.strobe) begin
          inc_elapsed = 1'b1;
          if (elapsed_inc == target_q) begin
            state_d = S_DONE;
          end else if (pause) begin
            state_d = S_PAUSE;
          end
        end else if (pause) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
`else
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ctr.strobe) begin
          inc_elapsed = 1'b1;
          if (elapsed_inc == target_q) begin
            state_d = S_DONE;
          end
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (nRST) begin
      target_q  <= '0;
      max_q     <= '0;
      elapsed_q <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      ctr_rst_q <= 1'b1;
    end else begin
      if (load) begin
        target_q <= rounds;
        max_q    <= period;
      end
      if (clr_elapsed) begin
        elapsed_q <= '0;
      end else if (inc_elapsed) begin
        elapsed_q <= elapsed_inc;
      end
      tick_q    <= inc_elapsed;
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      en_q      <= (state_d == S_RUN);
      ctr_rst_q <= (state_d == S_ARM);
    end
  end

  // The counter also clears in the same cycle reset is requested
  assign ctr_clk           = clk;
  assign ctr.ctr_rst       = ctr_rst_q | nRST;
  assign ctr.enableCounter = en_q;
  assign ctr.maxCount      = max_q;

  assign tick    = tick_q;
  assign elapsed = elapsed_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Counter sanity: after ARM the count can never run past the terminal value while running
  a_count_in_range: assert property (
    @(posedge clk) disable iff (nRST)
    (state_q == S_RUN) |-> (ctr.count <= ctr.maxCount)
  );

endmodule

// File: doc/round_timer_ctrl.md
# round_timer_ctrl

Controller-side driver for a flex counter: owns the counter's clock, reset, enable and terminal count, and consumes its strobe to time gameplay rounds for the typing core. A round is a programmed number of ticks, each `period+1` clocks long. Produces per-tick pulses, an elapsed-tick count and a round-complete pulse for the game FSM.

## Interface
- `COUNTSIZE`, 1024: counter range; sets counter width.
- `COUNTWIDTH`, `$clog2(COUNTSIZE)`: width of `period`, `maxCount` and `count`.
- `ROUNDWIDTH`, 8: width of `rounds` and `elapsed`.

- `clk` in 1: the single clock.
- `nRST` in 1: reset; one clock; synchronous and active-high (port name kept for codebase consistency).
- `start` in 1: pulse; begins a round when idle.
- `abort` in 1: pulse; ends the round without `done`.
- `pause` in 1: level; holds the round (only with `ROUNDTIMER_PAUSE_EN`).
- `period` in COUNTWIDTH: clocks per tick minus 1; latched on accepted `start`.
- `rounds` in ROUNDWIDTH: ticks per round; latched on accepted `start`.
- `ctr_clk` out 1: counter clock, `clk` passed through.
- `ctr_rst` out 1: counter clear, active-high.
- `enableCounter` out 1: counter enable.
- `maxCount` out COUNTWIDTH: counter terminal value.
- `strobe` in 1: counter terminal-count pulse.
- `count` in COUNTWIDTH: counter value, monitor only.
- `tick` out 1: one-cycle pulse per completed tick.
- `elapsed` out ROUNDWIDTH: ticks completed this round.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle round-complete pulse.

## Operation
- Counter contract:
  - while `enableCounter`, `count` increments each clock;
  - `strobe` is high in the cycle `count==maxCount`, and `count` wraps to 0 on the next edge;
  - `ctr_rst` clears `count` to 0 on the next edge.
- States:
  - IDLE: `enableCounter=0`.
    - `start` with `rounds!=0`: latch `period` into `maxCount` and `rounds` into the target, clear `elapsed`, go to ARM.
    - `start` with `rounds==0`: clear `elapsed`, go to DONE.
  - ARM: one cycle, `ctr_rst=1`, `enableCounter=0`; go to RUN.
  - RUN: `enableCounter=1`.
    - On `strobe`: `tick=1` and `elapsed+1` on the next cycle.
    - If the new `elapsed` equals the target, go to DONE.
  - PAUSE (macro only): `enableCounter=0`, `count` frozen; `pause` low returns to RUN; `abort` goes to IDLE.
  - DONE: `done=1` for one cycle, `enableCounter=0`; go to IDLE.
- Priority per cycle: `nRST` > `abort` > `strobe` > `pause`.
  - `abort` in RUN or PAUSE goes to IDLE, drops a coincident strobe, and keeps `elapsed` for readout.
  - `strobe` together with `pause` in RUN: the tick is counted and the next state is PAUSE, unless that tick completes the round (then DONE).
- `start` while busy is ignored. `period`/`rounds` changes while busy have no effect.
- `elapsed` is ROUNDWIDTH wide and never wraps, because it stops at the target, which is at most `2^ROUNDWIDTH-1`.
- `period=0`: one tick per clock in RUN.
- `ctr_rst` is also high whenever `nRST` is high.

## Timing
- Reset, on the edge with `nRST` high: state IDLE; `enableCounter=0`, `maxCount=0`, `ctr_rst=1`, `tick=0`, `elapsed=0`, `busy=0`, `done=0`.
  - Applies mid-round too: no `done`, and the counter is cleared.
- `tick`, `elapsed`, `done` and `busy` are registered.
- `start` sampled at edge 0: ARM in cycle 1, RUN from cycle 2 with `count=0`.
  - First `strobe` in cycle 2+P, first `tick` in cycle 3+P.
  - Subsequent ticks every P+1 cycles.
- On the final tick, `done` coincides with `tick`; `busy` falls one cycle later.
- `start` with `rounds=0`: `done` in cycle 1, no ticks.
- PAUSE adds exactly its duration to the remaining ticks; the partial period resumes from the frozen `count`.
- A new `start` is accepted the cycle after `busy` falls.

## Configuration
- `ROUNDTIMER_PAUSE_EN` defined: `pause` port present; PAUSE state and its transitions are implemented.
- Not defined: `pause` port absent and PAUSE state not built. RUN exits only via the final tick, `abort` or reset.

## Test plan
- Reset then idle: all outputs at reset values; `start` with `period=3`, `rounds=2` -> ticks in cycles 6 and 10, `elapsed` 1 then 2, `done` in cycle 10, `busy` low in cycle 11.
- `rounds=0`, `start` -> `done` in cycle 1, no `tick`, `enableCounter` never high.
- `period=0`, `rounds=5` -> five consecutive single-cycle ticks in cycles 3–7, `done` with the 5th.
- `abort` coincident with a strobe on tick 2 of 4 -> no `tick`, `elapsed=1` held, no `done`, IDLE next cycle; `nRST` mid-round -> all outputs reset next cycle.
- `ROUNDTIMER_PAUSE_EN`, `period=9`: pause for 7 cycles at `count=4` -> `enableCounter` low for 7 cycles, `count` held at 4, tick delayed by 7 cycles; pause coincident with the strobe -> tick counted, then PAUSE.
- `start` pulsed while busy with different `period`/`rounds` -> ignored; original timing preserved.
